// File: rtl/mux_pkg.sv
// mux_pkg: shared sizing and round-robin helpers for multi-port muxes
package mux_pkg;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int last, input int n);
    return (last >= n - 1) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after the last winner
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic            found;
  logic [SELW-1:0] c;

  // walk channels from last+1 upward with explicit modulo-N wrap, first requester wins
  always_comb begin
    grant_idx = '0;
    found = 1'b0;
    c = SELW'(rr_next(int'(last), N));
    for (int k = 0; k < N; k++) begin
      if (!found && req[c]) begin
        found = 1'b1;
        grant_idx = c;
      end
      c = SELW'(rr_next(int'(c), N));
    end
    grant = (found && en) ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel registered round-robin mux with valid/ready handshakes
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] words [N];
  logic             load_en;
  logic             xfer;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  // output register may take a new word when empty or draining; never during reset
  always_comb begin
    load_en = !reset && (!out_valid || out_ready);
    xfer = load_en && |in_valid;
  end

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .last      (last),
    .en        (load_en),
    .grant     (in_ready),
    .grant_idx (grant_idx)
  );

  // output stage and pointer: load on transfer, clear on drain, freeze on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      last <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= words[grant_idx];
      out_sel <= grant_idx;
      last <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed stimulus with scoreboard-checked output words
module tb_rr_mux_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q [$];

  rr_mux_arbiter #(.WIDTH(32), .N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setd(input int i, input logic [31:0] w);
    in_data[i*32 +: 32] = w;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected: got sel=%0d data=%h with nothing expected", out_sel, out_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({out_sel, out_data} !== e) begin
          failures++;
          $display("FAIL word: got sel=%0d data=%h expected sel=%0d data=%h", out_sel, out_data, e[33:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 4'b0000;
    in_data = '0;
    out_ready = 1'b0;
    step();
    in_valid = 4'b1111;
    chk("ready_in_reset", 64'(in_ready), 64'h0);
    step();
    reset = 1'b0;
    in_valid = 4'b0000;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    chk("rst_idle_ready", 64'(in_ready), 64'h0);

    out_ready = 1'b1;
    in_valid = 4'b0100;
    setd(2, 32'h12345678);
    #1;
    chk("single_ready", 64'(in_ready), 64'h4);
    exp_q.push_back({2'd2, 32'h12345678});
    step();
    in_valid = 4'b0000;
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_data", 64'(out_data), 64'h12345678);
    chk("single_sel", 64'(out_sel), 64'h2);
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) setd(i, 32'h0000000F + 32'(i));
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rotate_ready%0d", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
      exp_q.push_back({2'(k % 4), 32'h0000000F + 32'(k % 4)});
      step();
      chk($sformatf("rotate_valid%0d", k), 64'(out_valid), 64'h1);
    end
    in_valid = 4'b0000;
    step();

    in_valid = 4'b0010;
    setd(1, 32'hFFFFFFFF);
    #1;
    chk("bp_ready_ch1", 64'(in_ready), 64'h2);
    exp_q.push_back({2'd1, 32'hFFFFFFFF});
    step();
    out_ready = 1'b0;
    in_valid = 4'b1001;
    setd(0, 32'hA0A0A0A0);
    setd(3, 32'hA3A3A3A3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), 64'(in_ready), 64'h0);
      chk($sformatf("bp_data%0d", k), 64'(out_data), 64'hFFFFFFFF);
      chk($sformatf("bp_sel%0d", k), 64'(out_sel), 64'h1);
      chk($sformatf("bp_valid%0d", k), 64'(out_valid), 64'h1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_grant_ch3", 64'(in_ready), 64'h8);
    exp_q.push_back({2'd3, 32'hA3A3A3A3});
    step();
    chk("bp_grant_ch0", 64'(in_ready), 64'h1);
    exp_q.push_back({2'd0, 32'hA0A0A0A0});
    step();
    in_valid = 4'b0000;
    chk("drain_holds_valid", 64'(out_valid), 64'h1);
    step();
    chk("drain_valid_low", 64'(out_valid), 64'h0);
    chk("drain_data_hold", 64'(out_data), 64'hA0A0A0A0);

    in_valid = 4'b0001;
    setd(0, 32'h00000055);
    #1;
    chk("after_drain_ready", 64'(in_ready), 64'h1);
    exp_q.push_back({2'd0, 32'h00000055});
    step();
    in_valid = 4'b0000;
    step();
    chk("after_drain_idle", 64'(out_valid), 64'h0);

    in_valid = 4'b0100;
    setd(2, 32'h80000000);
    #1;
    chk("stall_ready_ch2", 64'(in_ready), 64'h4);
    step();
    out_ready = 1'b0;
    in_valid = 4'b0000;
    chk("stall_data", 64'(out_data), 64'h80000000);
    step();
    reset = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("midrst_ready", 64'(in_ready), 64'h0);
    step();
    reset = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_data", 64'(out_data), 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) setd(i, 32'h0000000F + 32'(i));
    #1;
    chk("midrst_first_ch0", 64'(in_ready), 64'h1);
    exp_q.push_back({2'd0, 32'h0000000F});
    step();
    in_valid = 4'b0000;
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
